prog_load_ctrl: RTL and testbench

- Boot/sequencing controller in front of the processor core.
- Accepts a program image from a host over a valid/ready word stream and buffers it whole.
- Replays the image to the processor's load interface (new_instruction/add_into) at one word per clock, with no gaps. It then raises start_signal and supervises the run until end_signal or a timeout.
- Reports status and the run cycle count to the host.

---
 rtl/prog_load_ctrl_pkg.sv | 33 +++
 rtl/prog_image_buf.sv | 27 ++
 rtl/prog_load_ctrl.sv | 161 ++++++++++++++++
 tb/tb_prog_load_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the program-load controller.
//   state_t      : controller states
//   ERR_*        : err_code values reported to the host
//   HDR_*        : bit positions of the I/D counts inside the header word
//   hdr_total()  : 17-bit I+D sum so oversized 16-bit fields cannot wrap
package prog_load_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        PRESET,
        STREAM_I,
        STREAM_D,
        RUN,
        DONE,
        ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ZERO_I  = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int HDR_I_LSB = 0;
    localparam int HDR_I_MSB = 15;
    localparam int HDR_D_LSB = 16;
    localparam int HDR_D_MSB = 31;

    function automatic logic [16:0] hdr_total(input logic [31:0] hdr);
        return {1'b0, hdr[HDR_I_MSB:HDR_I_LSB]} + {1'b0, hdr[HDR_D_MSB:HDR_D_LSB]};
    endfunction

endpackage

// File: rtl/prog_image_buf.sv
// Program image buffer: DEPTH x 32 RAM, one write port, one registered read port.
//   clk    : clock
//   we     : write enable, waddr/wdata : write address / data
//   re     : read enable,  raddr       : read address
//   rdata  : read data, valid the clock after re
module prog_image_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // No reset: contents are only read back after being written by a load.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot/sequencing controller in front of the processor core.
// Collects a host image (header + I instruction words + D data words) into a
// buffer, replays it gap-free to the processor load port, then runs the core
// until end_signal or a watchdog timeout.
//   clk, reset            : clock, async active-low reset
//   in_valid/in_ready/in_data : host word stream (first word is the header)
//   ack                   : host clears DONE/ERROR
//   proc_reset            : one-cycle reset pulse to the processor
//   new_instruction/add_into : processor load port (add_into 1 = data memory)
//   start_signal/end_signal  : processor run enable / completion
//   busy, done, error, err_code, run_cycles : status to host
module prog_load_ctrl
    import prog_load_ctrl_pkg::*;
#(
    parameter int          DEPTH          = 64,
    parameter int          AW             = 6,
    parameter int unsigned MAX_RUN_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        ack,
    output logic        proc_reset,
    output logic [31:0] new_instruction,
    output logic        add_into,
    output logic        start_signal,
    input  logic        end_signal,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] run_cycles
);

    localparam logic [16:0]   DEPTH17 = 17'(DEPTH);
    localparam logic [31:0]   MAX32   = 32'(MAX_RUN_CYCLES);
    localparam logic [AW-1:0] WLAST   = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [1:0]    err_q, err_d;
    logic          out_en_q;          // holds in_ready low until the first clock after reset
    logic [AW-1:0] wptr_q;
    logic [AW:0]   wcnt_q, wcnt_nxt;  // words accepted; one bit wider than wptr to reach DEPTH
    logic [AW:0]   rptr_q;            // next word to read; one ahead of the word on the port
    logic [AW:0]   icnt_q, dcnt_q, tot;
    logic [31:0]   run_cycles_q, run_nxt;

    logic [15:0]   hdr_i;
    logic [16:0]   hdr_sum;
    logic          xfer;
    logic          buf_we, buf_re;
    logic [31:0]   buf_rdata;

    assign hdr_i    = in_data[HDR_I_MSB:HDR_I_LSB];
    assign hdr_sum  = hdr_total(in_data);
    assign in_ready = out_en_q && (state_q == IDLE || state_q == COLLECT);
    assign xfer     = in_valid && in_ready;
    assign tot      = icnt_q + dcnt_q;
    assign wcnt_nxt = wcnt_q + 1'b1;
    assign run_nxt  = run_cycles_q + 32'd1;

    assign buf_we = (state_q == COLLECT) && xfer;
    // Read runs from PRESET onward so word 0 is already registered when STREAM_I starts.
    assign buf_re = (state_q == PRESET) || (state_q == STREAM_I) || (state_q == STREAM_D);

    prog_image_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wptr_q),
        .wdata (in_data),
        .re    (buf_re),
        .raddr (rptr_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_i == 16'd0) begin
                        state_d = ERROR;
                        err_d   = ERR_ZERO_I;
                    end else if (hdr_sum > DEPTH17) begin
                        state_d = ERROR;
                        err_d   = ERR_OVF;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: if (xfer && wcnt_nxt == tot) state_d = PRESET;
            PRESET:  state_d = STREAM_I;
            // rptr_q == k+1 while word k is on the port.
            STREAM_I: if (rptr_q == icnt_q) state_d = (dcnt_q == '0) ? RUN : STREAM_D;
            STREAM_D: if (rptr_q == tot) state_d = RUN;
            RUN: begin
                if (end_signal) begin
                    state_d = DONE;
                end else if (run_nxt == MAX32) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            DONE: if (ack) state_d = IDLE;
            ERROR: begin
                if (ack) begin
                    state_d = IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            err_q        <= ERR_NONE;
            out_en_q     <= 1'b0;
            wptr_q       <= '0;
            wcnt_q       <= '0;
            rptr_q       <= '0;
            icnt_q       <= '0;
            dcnt_q       <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            out_en_q <= 1'b1;
            if (state_q == IDLE && xfer) begin
                icnt_q       <= hdr_i[AW:0];
                dcnt_q       <= in_data[HDR_D_LSB +: AW+1];
                wptr_q       <= '0;
                wcnt_q       <= '0;
                rptr_q       <= '0;
                run_cycles_q <= '0;
            end
            if (buf_we) begin
                wptr_q <= (wptr_q == WLAST) ? '0 : wptr_q + 1'b1;
                wcnt_q <= wcnt_nxt;
            end
            if (buf_re) rptr_q <= rptr_q + 1'b1;
            if (state_q == RUN) run_cycles_q <= run_nxt;
        end
    end

    assign proc_reset      = (state_q == PRESET);
    assign new_instruction = (state_q == STREAM_I || state_q == STREAM_D) ? buf_rdata : 32'd0;
    assign add_into        = (state_q == STREAM_D) || (state_q == RUN && dcnt_q != '0);
    assign start_signal    = (state_q == RUN);
    assign busy            = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done            = (state_q == DONE);
    assign error           = (state_q == ERROR);
    assign err_code        = err_q;
    assign run_cycles      = run_cycles_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
module tb_prog_load_ctrl;

    localparam int DEPTH = 64;
    localparam int MAXR  = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, ack, proc_reset, add_into;
    logic        start_signal, end_signal, busy, done, error;
    logic [31:0] in_data, new_instruction, run_cycles;
    logic [1:0]  err_code;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    prog_load_ctrl #(.DEPTH(DEPTH), .AW(6), .MAX_RUN_CYCLES(MAXR)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .ack             (ack),
        .proc_reset      (proc_reset),
        .new_instruction (new_instruction),
        .add_into        (add_into),
        .start_signal    (start_signal),
        .end_signal      (end_signal),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_code        (err_code),
        .run_cycles      (run_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outcome of a header from the load rules: 0 = accepted, else the error code.
    function automatic int exp_code(input int ni, input int nd);
        if (ni == 0) return 1;
        if (ni + nd > DEPTH) return 2;
        return 0;
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},  in_ready, 0);
        chk({tag, "_prst"}, proc_reset, 0);
        chk({tag, "_ni"},   new_instruction, 0);
        chk({tag, "_add"},  add_into, 0);
        chk({tag, "_start"}, start_signal, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"},  error, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_rc"},   run_cycles, 0);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", in_ready, 1);
    endtask

    task automatic send_hdr(input int ni, input int nd);
        wait_ready();
        in_valid = 1'b1;
        in_data  = {nd[15:0], ni[15:0]};
        @(negedge clk);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_done", done, 0);
        chk("ack_err", error, 0);
        chk("ack_code", err_code, 0);
        chk("ack_busy", busy, 0);
        chk("ack_rdy", in_ready, 1);
    endtask

    task automatic bad_hdr(input int ni, input int nd);
        int code;
        code = exp_code(ni, nd);
        send_hdr(ni, nd);
        in_data = $urandom;              // still offered, must be ignored
        for (int c = 0; c < 3; c++) begin
            chk("bad_err", error, 1);
            chk("bad_code", err_code, code);
            chk("bad_rdy", in_ready, 0);
            chk("bad_start", start_signal, 0);
            end_signal = 1'b1;           // ignored outside RUN
            @(negedge clk);
        end
        end_signal = 1'b0;
        in_valid   = 1'b0;
        do_ack();
    endtask

    // end_at: RUN cycle (1-based) in which end_signal is raised; 0 or >MAXR = never.
    // abort_at: stream index at which reset is pulsed; -1 = never.
    task automatic do_load(input int ni, input int nd, input bit gappy,
                           input int end_at, input int abort_at);
        logic [31:0] img [$];
        logic [31:0] w;
        int tot, lim;
        tot = ni + nd;
        lim = (end_at >= 1 && end_at <= MAXR) ? end_at : MAXR;
        send_hdr(ni, nd);
        chk("collect_busy", busy, 1);
        chk("collect_rdy", in_ready, 1);
        chk("rc_clear", run_cycles, 0);
        for (int k = 0; k < tot; k++) begin
            if (gappy) begin
                in_valid = 1'b0;
                in_data  = $urandom;     // not accepted, must not be stored
                @(negedge clk);
            end
            w = $urandom;
            img.push_back(w);
            in_valid = 1'b1;
            in_data  = w;
            @(negedge clk);
        end
        in_data = $urandom;              // in_valid held high, must be ignored
        chk("preset_pulse", proc_reset, 1);
        chk("preset_rdy", in_ready, 0);
        chk("preset_start", start_signal, 0);
        @(negedge clk);
        for (int k = 0; k < tot; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outs("abort");
                @(negedge clk);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                chk("abort_rdy_low", in_ready, 0);
                @(negedge clk);
                chk("abort_rdy_up", in_ready, 1);
                return;
            end
            chk("stream_word", new_instruction, img[k]);
            chk("stream_add", add_into, (k >= ni) ? 1 : 0);
            chk("stream_prst", proc_reset, 0);
            chk("stream_start", start_signal, 0);
            end_signal = 1'($urandom);   // ignored outside RUN
            ack        = 1'($urandom);   // ignored outside DONE/ERROR
            @(negedge clk);
        end
        in_valid = 1'b0;
        ack      = 1'b0;
        for (int j = 1; j <= lim; j++) begin
            chk("run_start", start_signal, 1);
            chk("run_ni", new_instruction, 0);
            chk("run_add", add_into, (nd != 0) ? 1 : 0);
            end_signal = (j == end_at);
            @(negedge clk);
        end
        end_signal = 1'b0;
        if (end_at >= 1 && end_at <= MAXR) begin
            chk("end_done", done, 1);
            chk("end_err", error, 0);
        end else begin
            chk("to_err", error, 1);
            chk("to_code", err_code, 3);
        end
        chk("end_start", start_signal, 0);
        chk("end_rc", run_cycles, lim);
        chk("end_busy", busy, 0);
        @(negedge clk);
        chk("rc_frozen", run_cycles, lim);
        do_ack();
    endtask

    initial begin
        int ni, nd, ea;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ack = 1'b0; end_signal = 1'b0;
        #1;
        chk_reset_outs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rdy_low", in_ready, 0);
        @(negedge clk);
        chk("rst_rdy_up", in_ready, 1);

        do_load(23, 11, 1'b0, 50, -1);
        do_load(5, 0, 1'b1, 7, -1);
        bad_hdr(0, 3);
        bad_hdr(60, 5);
        do_load(60, 4, 1'b0, 10, -1);
        do_load(3, 2, 1'b0, 0, -1);           // watchdog timeout
        do_load(2, 2, 1'b0, MAXR, -1);        // end in the last allowed cycle wins
        do_load(4, 6, 1'b0, 5, 7);            // reset during STREAM_D
        do_load(2, 1, 1'b0, 3, -1);
        bad_hdr(16'hFFFF, 1);                 // 17-bit sum must not wrap
        do_load(40, 24, 1'b1, 2, -1);         // exactly DEPTH words
        do_load(1, 0, 1'b0, 1, -1);

        for (int r = 0; r < 14; r++) begin
            ni = $urandom_range(0, 40);
            nd = $urandom_range(0, 40);
            ea = $urandom_range(1, MAXR + 20);
            if (exp_code(ni, nd) != 0) bad_hdr(ni, nd);
            else do_load(ni, nd, 1'($urandom), ea, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
